instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Fetch stage sitting directly downstream of the program counter (`counter`).
- Takes the current PC value and issues one instruction-memory read per PC.
- Pulses the counter to advance the PC once each request is granted.
- Buffers returned instructions with their PC in a small queue and hands them to decode over a valid/ready handshake. Branch/jump flush drops all in-flight and buffered fetches.

Parameters:
- XLEN, 32, width of PC and memory address.
- ILEN, 32, instruction width.
- FQ_DEPTH, 2, fetch queue entries (power of two, ≥2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_in  in  XLEN  current PC from counter `out`.
- pc_advance  out  1  one-cycle pulse; counter increments PC.
- imem_req  out  1  read request.
- imem_addr  out  XLEN  request address (= pc_in).
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  ILEN  read data.
- flush  in  1  redirect; counter is reloaded externally the same cycle.
- id_valid  out  1  decode-side entry valid.
- id_ready  in  1  decode accepts entry.
- id_instr  out  ILEN  instruction at queue head.
- id_pc  out  XLEN  PC of that instruction.

Behaviour:
- Everything in this block uses one clock, clk. Reset is synchronous and active-high: reset=1 at a rising edge of clk puts the block into its reset state. Reset has priority over every other input.
- Reset values: state=IDLE, queue empty, id_valid=0, id_instr=0, id_pc=0. imem_req and pc_advance are forced 0 while reset=1.
- At most one outstanding memory request.
- FSM states: IDLE, WAIT, DROP.
- IDLE:
  - imem_req=1 when flush=0 and (queue count + 0) < FQ_DEPTH; imem_addr=pc_in.
  - On imem_req & imem_gnt: pc_advance=1 combinationally in the same cycle, pc_in is latched into pending_pc, next state is WAIT.
- WAIT:
  - imem_req=0.
  - On imem_rvalid (flush=0): push {pending_pc, imem_rdata}, next state IDLE.
  - On flush without rvalid: next state DROP.
  - On flush with rvalid in the same cycle: discard the data, next state IDLE.
- DROP:
  - imem_req=0.
  - The next imem_rvalid is discarded, next state IDLE.
- imem_rvalid while in IDLE is ignored.
- Space reservation: a request issues only when a queue slot is free, so a push never overflows.
- Issue is from IDLE only, so peak throughput is 1 instruction per 2 cycles with 1-cycle memory.
- Queue:
  - FIFO, in-order.
  - Pop when id_valid & id_ready.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - id_valid = queue non-empty. id_instr/id_pc are the registered head and are stable while id_valid & !id_ready.
- Latency: grant at cycle T, rvalid at T+k (k≥1) → id_valid at T+k+1 if the queue was empty.
- flush:
  - Empties the queue next cycle (id_valid=0 at T+1).
  - Suppresses imem_req and pc_advance in the flush cycle.
  - A pop in the flush cycle is still legal (decode sees the handshake), but its entry is discarded anyway.
  - flush is not an error in any state.
- Reset mid-operation: any response arriving after reset deasserts while in IDLE is ignored (rvalid in IDLE rule).
- PC wrap-around is the counter's concern; the PC is passed through unmodified.

Decomposition:
- Package fetch_pkg: XLEN/ILEN defaults, FSM state enum {IDLE, WAIT, DROP}, fetch-entry struct {pc, instr}.
- One sub-module: fetch_fifo (parameterised depth/width).
  - Ports: push, pop, clear, din, dout, count, empty, full.
  - Synchronous reset and clear.

Test Plan:
- Reset: hold reset 2 cycles with imem_gnt=1, imem_rvalid=1 → imem_req=0, pc_advance=0, id_valid=0 throughout; first request appears in the cycle after reset falls.
- Single fetch: pc_in=0x00000000, gnt in the same cycle, rvalid next cycle with 0x00500093 → pc_advance exactly one pulse. Next cycle: id_valid=1, id_instr=0x00500093, id_pc=0x00000000.
- Backpressure: id_ready=0, PCs 0x0, 0x4, 0x8 offered → two entries fetched, then imem_req stays 0. Raise id_ready → pops in order 0x0, 0x4, then 0x8 is fetched.
- Flush in WAIT: grant at pc 0x10, flush next cycle, rvalid two cycles later with 0xDEADBEEF → never appears on id_instr. Next request uses the new pc_in 0x100.
- Flush on a full queue in the same cycle as rvalid → queue empty and id_valid=0 next cycle; state IDLE; no pc_advance in the flush cycle.
- Reset while in WAIT, rvalid arriving after reset deasserts → ignored; id_valid stays 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, FSM states and queue entry layout for the fetch stage
package fetch_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: PC, instruction-memory and decode-side signals of the fetch stage
interface instr_fetch_if #(
  parameter int XLEN = fetch_pkg::XLEN,
  parameter int ILEN = fetch_pkg::ILEN
);
  import fetch_pkg::*;
  logic [XLEN-1:0] pc_in;
  logic            pc_advance;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [ILEN-1:0] imem_rdata;
  logic            flush;
  logic            id_valid;
  logic            id_ready;
  logic [ILEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;
  modport master (
    input  pc_in, imem_gnt, imem_rvalid, imem_rdata, flush, id_ready,
    output pc_advance, imem_req, imem_addr, id_valid, id_instr, id_pc
  );
  modport slave (
    output pc_in, imem_gnt, imem_rvalid, imem_rdata, flush, id_ready,
    input  pc_advance, imem_req, imem_addr, id_valid, id_instr, id_pc
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: in-order queue with synchronous clear; head reads as zero when empty
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr, rd;
  assign empty = count == '0;
  assign full = 32'(count) == DEPTH;
  assign wr = push && !full;
  assign rd = pop && !empty;
  assign dout = empty ? '0 : mem[rd_ptr];
  // storage needs no reset: entries are only visible once counted
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= din;
  // pointers and occupancy; clear drops everything, even a same-cycle push
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
    end
  end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: one-outstanding-request fetch stage feeding decode through a small queue
module instr_fetch #(
  parameter int XLEN = fetch_pkg::XLEN,
  parameter int ILEN = fetch_pkg::ILEN,
  parameter int FQ_DEPTH = 2
) (
  input logic clk,
  input logic reset,
  instr_fetch_if.master bus
);
  import fetch_pkg::*;
  localparam int CW = $clog2(FQ_DEPTH) + 1;
  state_t state, next_state;
  logic [XLEN-1:0] pending_pc;
  logic [XLEN+ILEN-1:0] head;
  logic [CW-1:0] count;
  logic push, pop, empty, full_unused;
  fetch_fifo #(.DEPTH(FQ_DEPTH), .WIDTH(XLEN + ILEN)) fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .clear(bus.flush),
    .din({pending_pc, bus.imem_rdata}),
    .dout(head),
    .count(count),
    .empty(empty),
    .full(full_unused)
  );
  assign {bus.id_pc, bus.id_instr} = head;
  assign bus.id_valid = !empty;
  assign pop = bus.id_valid && bus.id_ready;
  assign bus.imem_addr = bus.pc_in;
  // issue only from IDLE with a free slot reserved; WAIT/DROP consume exactly one response
  always_comb begin
    next_state = state;
    bus.imem_req = 1'b0;
    bus.pc_advance = 1'b0;
    push = 1'b0;
    case (state)
      IDLE: begin
        bus.imem_req = !reset && !bus.flush && 32'(count) < FQ_DEPTH;
        bus.pc_advance = bus.imem_req && bus.imem_gnt;
        next_state = bus.pc_advance ? WAIT : IDLE;
      end
      WAIT: begin
        push = bus.imem_rvalid && !bus.flush;
        next_state = bus.imem_rvalid ? IDLE : bus.flush ? DROP : WAIT;
      end
      DROP: next_state = bus.imem_rvalid ? IDLE : DROP;
      default: next_state = IDLE;
    endcase
  end
  // state register and PC of the request in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pending_pc <= '0;
    end else begin
      state <= next_state;
      if (bus.pc_advance) pending_pc <= bus.pc_in;
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed plus random stimulus against a queue-based model of the fetch stage
module tb_instr_fetch;
  import fetch_pkg::*;
  localparam int FQ_DEPTH = 2;
  logic clk, reset;
  instr_fetch_if bus ();
  instr_fetch #(.XLEN(32), .ILEN(32), .FQ_DEPTH(FQ_DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;

  int total = 0, bad = 0;
  bit checking = 0;
  fetch_entry_t exp_q[$];
  fetch_entry_t push_ent;
  bit clr_pend = 0, push_pend = 0;
  bit busy = 0, drop = 0, prev_r = 0, post_rst = 0;
  bit exp_req = 0, exp_adv = 0;
  logic [31:0] out_pc = 0;
  int lat = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // one cycle: commit last cycle's queue effects, drive inputs, predict this cycle
  task automatic step(input bit r, input bit f, input bit g, input bit v,
                      input logic [31:0] d, input logic [31:0] p, input bit rdy);
    @(posedge clk);
    #1;
    if (clr_pend) exp_q.delete();
    if (push_pend) exp_q.push_back(push_ent);
    clr_pend = 0;
    push_pend = 0;
    post_rst = prev_r;
    prev_r = r;
    reset = r;
    bus.flush = f;
    bus.imem_gnt = g;
    bus.imem_rvalid = v;
    bus.imem_rdata = d;
    bus.pc_in = p;
    bus.id_ready = rdy;
    exp_req = !r && !busy && !f && exp_q.size() < FQ_DEPTH;
    exp_adv = exp_req && g;
    if (r) begin
      clr_pend = 1;
      busy = 0;
    end else begin
      if (f) clr_pend = 1;
      if (busy && v) begin
        busy = 0;
        if (!drop && !f) begin
          push_pend = 1;
          push_ent = '{pc: out_pc, instr: d};
        end
      end else if (busy && f) drop = 1;
      if (exp_adv) begin
        busy = 1;
        drop = 0;
        out_pc = p;
        lat = $urandom_range(0, 2);
      end
    end
  endtask

  // monitor: request side every cycle, queue head whenever decode sees a valid entry
  always @(negedge clk) begin
    if (checking) begin
      chk("imem_req", {31'b0, bus.imem_req}, {31'b0, exp_req});
      chk("pc_advance", {31'b0, bus.pc_advance}, {31'b0, exp_adv});
      if (exp_req) chk("imem_addr", bus.imem_addr, bus.pc_in);
      chk("id_valid", {31'b0, bus.id_valid}, {31'b0, exp_q.size() != 0});
      if (post_rst) begin
        chk("rst_id_instr", bus.id_instr, 32'h0);
        chk("rst_id_pc", bus.id_pc, 32'h0);
      end
      if (bus.id_valid && exp_q.size() != 0) begin
        chk("id_pc", bus.id_pc, exp_q[0].pc);
        chk("id_instr", bus.id_instr, exp_q[0].instr);
        if (bus.id_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    bit r, f, g, v, rdy;
    clk = 0;
    reset = 1;
    bus.flush = 0;
    bus.imem_gnt = 0;
    bus.imem_rvalid = 0;
    bus.imem_rdata = 0;
    bus.pc_in = 0;
    bus.id_ready = 0;
    step(1, 0, 1, 1, 32'h0, 32'h0, 0);
    checking = 1;
    step(1, 0, 1, 1, 32'h0, 32'h0, 0);
    step(0, 0, 1, 0, 32'h0, 32'h0, 1);
    step(0, 0, 0, 1, 32'h00500093, 32'h4, 1);
    step(0, 0, 0, 0, 32'h0, 32'h4, 1);
    step(0, 0, 0, 0, 32'h0, 32'h4, 0);
    step(0, 0, 1, 0, 32'h0, 32'h0, 0);
    step(0, 0, 0, 1, 32'h11, 32'h4, 0);
    step(0, 0, 1, 0, 32'h0, 32'h4, 0);
    step(0, 0, 0, 1, 32'h22, 32'h8, 0);
    repeat (3) step(0, 0, 1, 0, 32'h0, 32'h8, 0);
    step(0, 0, 1, 0, 32'h0, 32'h8, 1);
    step(0, 0, 1, 0, 32'h0, 32'h8, 1);
    step(0, 0, 0, 1, 32'h33, 32'hc, 1);
    step(0, 0, 0, 0, 32'h0, 32'hc, 1);
    step(0, 0, 1, 0, 32'h0, 32'h10, 1);
    step(0, 1, 0, 0, 32'h0, 32'h14, 1);
    step(0, 0, 0, 0, 32'h0, 32'h100, 1);
    step(0, 0, 1, 1, 32'hdeadbeef, 32'h100, 1);
    step(0, 0, 1, 0, 32'h0, 32'h100, 1);
    step(0, 0, 0, 1, 32'h44, 32'h104, 1);
    step(0, 0, 0, 0, 32'h0, 32'h104, 0);
    step(0, 0, 1, 0, 32'h0, 32'h200, 0);
    step(0, 0, 0, 1, 32'h55, 32'h204, 0);
    step(0, 0, 1, 0, 32'h0, 32'h204, 0);
    step(0, 0, 0, 1, 32'h66, 32'h208, 0);
    step(0, 1, 1, 1, 32'h77, 32'h300, 1);
    step(0, 0, 0, 0, 32'h0, 32'h300, 0);
    step(0, 0, 1, 0, 32'h0, 32'h400, 0);
    step(0, 0, 0, 1, 32'h88, 32'h404, 0);
    step(0, 0, 1, 0, 32'h0, 32'h404, 0);
    step(0, 1, 0, 1, 32'h99, 32'h500, 0);
    step(0, 0, 0, 0, 32'h0, 32'h500, 0);
    step(0, 0, 1, 0, 32'h0, 32'h600, 1);
    step(1, 0, 0, 0, 32'h0, 32'h604, 1);
    step(0, 0, 0, 1, 32'hbad, 32'h604, 1);
    step(0, 0, 0, 0, 32'h0, 32'h604, 1);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 299) == 0;
      f = $urandom_range(0, 9) == 0;
      g = $urandom_range(0, 3) != 0;
      if (busy) begin
        v = lat == 0;
        if (lat != 0) lat--;
      end else v = $urandom_range(0, 7) == 0;
      rdy = $urandom_range(0, 2) != 0;
      step(r, f, g, v, $urandom, $urandom & 32'hffff_fffc, rdy);
    end
    repeat (4) step(0, 0, 0, 0, 32'h0, 32'h0, 1);
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
